// File: rtl/pipe_if_id_pkg.sv
// rtl/pipe_if_id_pkg.sv - shared encodings for the IF/ID pipeline register
package pipe_if_id_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OP   = 5'b00000;

  typedef enum logic [2:0] {
    RST_BUB = 3'd0,
    RUN     = 3'd1,
    HOLD    = 3'd2,
    SQUASH  = 3'd3,
    HALTED  = 3'd4
  } state_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == HALT_OP;
  endfunction

endpackage

// File: rtl/pipe_if_id_if.sv
// rtl/pipe_if_id_if.sv - fetch/decode signal bundle for the IF/ID register
interface pipe_if_id_if;

  logic [15:0] instruction;
  logic [15:0] pc_cur;
  logic [15:0] pc_next;
  logic        fetch_valid;
  logic        stall_decode;
  logic        flush;

  logic [15:0] instruction_o;
  logic [15:0] pc_cur_o;
  logic [15:0] pc_next_o;
  logic        valid_o;
  logic        stall_fetch_o;
  logic [15:0] bubble_cnt_o;

  modport master (
    output instruction, pc_cur, pc_next, fetch_valid, stall_decode, flush,
    input  instruction_o, pc_cur_o, pc_next_o, valid_o, stall_fetch_o, bubble_cnt_o
  );

  modport slave (
    input  instruction, pc_cur, pc_next, fetch_valid, stall_decode, flush,
    output instruction_o, pc_cur_o, pc_next_o, valid_o, stall_fetch_o, bubble_cnt_o
  );

endinterface

// File: rtl/dff.sv
// rtl/dff.sv - plain D flip-flop cell with synchronous active-high reset
module dff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // register with reset to the cell's configured value
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/pipe_if_id_dff_en.sv
// rtl/pipe_if_id_dff_en.sv - enable-hold register built around a dff cell
module pipe_if_id_dff_en #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] hold_d;

  // recirculate the current value when not enabled
  always_comb hold_d = en ? d : q;

  dff #(.W(W), .RST_VAL(RST_VAL)) u_dff (
    .clk (clk),
    .rst (rst),
    .d   (hold_d),
    .q   (q)
  );

endmodule

// File: rtl/pipe_if_id.sv
// rtl/pipe_if_id.sv - IF/ID pipeline register with stall/flush/halt control; PIPE_IF_ID_BUBBLE_CNT_EN adds a bubble counter
module pipe_if_id
  import pipe_if_id_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  pipe_if_id_if.slave  bus
);

  state_t      state_q, state_d;
  logic [2:0]  state_raw_q;
  logic        load_en, pc_load;
  logic [15:0] instr_d, instr_q, pc_cur_d, pc_cur_q, pc_next_d, pc_next_q;
  logic        valid_d, valid_q;

  assign state_q = state_t'(state_raw_q);

  // next-state and register-load decode; RST_BUB already shows the NOP, so
  // its exit edge takes the word the stalled fetch has been presenting
  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    pc_load   = 1'b0;
    instr_d   = NOP_INSTR;
    valid_d   = 1'b0;
    pc_cur_d  = bus.pc_cur;
    pc_next_d = bus.pc_next;
    if (bus.flush) begin
      load_en   = 1'b1;
      pc_load   = 1'b1;
      pc_cur_d  = 16'h0000;
      pc_next_d = 16'h0000;
      state_d   = SQUASH;
    end else begin
      case (state_q)
        RST_BUB: begin
          load_en = 1'b1;
          state_d = RUN;
          if (bus.fetch_valid) begin
            instr_d = bus.instruction;
            valid_d = 1'b1;
            pc_load = 1'b1;
          end
        end
        SQUASH: begin
          load_en = 1'b1;
          state_d = RUN;
        end
        HALTED: begin
          load_en = 1'b1;
        end
        default: begin
          if (bus.stall_decode) begin
            state_d = HOLD;
          end else begin
            load_en = 1'b1;
            state_d = RUN;
            if (bus.fetch_valid) begin
              instr_d = bus.instruction;
              valid_d = 1'b1;
              pc_load = 1'b1;
              if (is_halt(bus.instruction)) state_d = HALTED;
            end
          end
        end
      endcase
    end
  end

  dff #(.W(3), .RST_VAL(3'(RST_BUB))) u_state (
    .clk (clk), .rst (rst), .d (3'(state_d)), .q (state_raw_q)
  );

  pipe_if_id_dff_en #(.W(16), .RST_VAL(NOP_INSTR)) u_instr (
    .clk (clk), .rst (rst), .en (load_en), .d (instr_d), .q (instr_q)
  );

  pipe_if_id_dff_en #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk (clk), .rst (rst), .en (load_en), .d (valid_d), .q (valid_q)
  );

  pipe_if_id_dff_en #(.W(16), .RST_VAL(16'h0000)) u_pc_cur (
    .clk (clk), .rst (rst), .en (pc_load), .d (pc_cur_d), .q (pc_cur_q)
  );

  pipe_if_id_dff_en #(.W(16), .RST_VAL(16'h0000)) u_pc_next (
    .clk (clk), .rst (rst), .en (pc_load), .d (pc_next_d), .q (pc_next_q)
  );

  assign bus.instruction_o = instr_q;
  assign bus.valid_o       = valid_q;
  assign bus.pc_cur_o      = pc_cur_q;
  assign bus.pc_next_o     = pc_next_q;
  assign bus.stall_fetch_o = (bus.stall_decode & ~bus.flush)
                           | ((state_q == HALTED) & ~bus.flush)
                           | (state_q == RST_BUB);

`ifdef PIPE_IF_ID_BUBBLE_CNT_EN
  logic        bubble_inc;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;

  // a bubble is an edge loading valid_o=0 outside RST_BUB/HALTED; holds never count
  always_comb begin
    bubble_inc = 1'b0;
    if (bus.flush)
      bubble_inc = (state_q != RST_BUB) && (state_q != HALTED);
    else if (state_q == SQUASH)
      bubble_inc = 1'b1;
    else if ((state_q == RUN) || (state_q == HOLD))
      bubble_inc = !bus.stall_decode && !bus.fetch_valid;
  end

  // saturating increment
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_inc && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  dff #(.W(16), .RST_VAL(16'h0000)) u_bubble_cnt (
    .clk (clk), .rst (rst), .d (bubble_cnt_d), .q (bubble_cnt_q)
  );

  assign bus.bubble_cnt_o = bubble_cnt_q;
`else
  assign bus.bubble_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_if_id.sv
// tb/tb_pipe_if_id.sv - self-checking bench for pipe_if_id against a behavioural model
module tb_pipe_if_id;

  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_if_id_if bus();

  pipe_if_id u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model: what the decode stage should see
  logic [15:0] m_instr, m_pcc, m_pcn, m_cnt;
  logic        m_valid;
  bit          m_boot   = 1'b1;
  bit          m_squash = 1'b0;
  bit          m_halted = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bump();
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic drop();
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  task automatic step(input logic r, input logic f, input logic s, input logic fv,
                      input logic [15:0] ins);
    logic [15:0] pc;
    logic        exp_sf;
    logic [15:0] exp_cnt;
    pc = 16'($urandom) & 16'hFFFE;
    rst              = r;
    bus.flush        = f;
    bus.stall_decode = s;
    bus.fetch_valid  = fv;
    bus.instruction  = ins;
    bus.pc_cur       = pc;
    bus.pc_next      = pc + 16'd2;
    #1;
    exp_sf = (s && !f) || (m_halted && !f) || m_boot;
    if (!r) chk("stall_fetch", {15'b0, bus.stall_fetch_o}, {15'b0, exp_sf});

    if (r) begin
      drop(); m_pcc = 16'h0; m_pcn = 16'h0; m_cnt = 16'h0;
      m_boot = 1'b1; m_squash = 1'b0; m_halted = 1'b0;
    end else if (f) begin
      if (!m_boot && !m_halted) bump();
      drop(); m_pcc = 16'h0; m_pcn = 16'h0;
      m_squash = 1'b1; m_halted = 1'b0; m_boot = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (fv) begin m_instr = ins; m_valid = 1'b1; m_pcc = pc; m_pcn = pc + 16'd2; end
      else drop();
    end else if (m_squash) begin
      m_squash = 1'b0; drop(); bump();
    end else if (m_halted) begin
      drop();
    end else if (s) begin
      // frozen
    end else if (fv) begin
      m_instr = ins; m_valid = 1'b1; m_pcc = pc; m_pcn = pc + 16'd2;
      if (ins[15:11] == 5'd0) m_halted = 1'b1;
    end else begin
      drop(); bump();
    end

    @(posedge clk);
    #1;
`ifdef PIPE_IF_ID_BUBBLE_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 16'h0000;
`endif
    chk("instruction_o", bus.instruction_o, m_instr);
    chk("valid_o",       {15'b0, bus.valid_o}, {15'b0, m_valid});
    chk("pc_cur_o",      bus.pc_cur_o, m_pcc);
    chk("pc_next_o",     bus.pc_next_o, m_pcn);
    chk("bubble_cnt_o",  bus.bubble_cnt_o, exp_cnt);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] cnt0, ins, exp_delta;
    logic        r, f, s, fv;
    rst = 1'b1;
    bus.flush = 1'b0; bus.stall_decode = 1'b0; bus.fetch_valid = 1'b0;
    bus.instruction = 16'h0; bus.pc_cur = 16'h0; bus.pc_next = 16'h0;
    m_cnt = 16'h0; m_instr = NOP; m_valid = 1'b0; m_pcc = 16'h0; m_pcn = 16'h0;
    repeat (2) @(negedge clk);

    // reset bubble, then the fetched word one edge later
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hC123);
    chk("rst_instr", bus.instruction_o, 16'h0800);
    chk("rst_stall_fetch", {15'b0, bus.stall_fetch_o}, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hC123);
    chk("first_word", bus.instruction_o, 16'hC123);

    // stall for three cycles with changing inputs, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'h9000 + 16'(i));
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hA55A);
    chk("release_word", bus.instruction_o, 16'hA55A);

    // stall and flush together, then a squashed word, then a valid one
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1111);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h2222);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h3333);
    chk("after_squash", bus.instruction_o, 16'h3333);

    // halt word, stuck until flush
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h4444);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h5555);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h6666);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);

    // five empty fetches, a flush and its squash cycle
    cnt0 = bus.bubble_cnt_o;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h8888);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h8888);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h8888);
`ifdef PIPE_IF_ID_BUBBLE_CNT_EN
    exp_delta = 16'd7;
`else
    exp_delta = 16'd0;
`endif
    chk("bubble_delta", bus.bubble_cnt_o - cnt0, exp_delta);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      f   = ($urandom_range(0, 19) == 0);
      s   = ($urandom_range(0, 4) == 0);
      fv  = ($urandom_range(0, 4) != 0);
      ins = 16'($urandom);
      if ($urandom_range(0, 24) == 0) ins[15:11] = 5'd0;
      step(r, f, s, fv, ins);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_if_id.md
PIPE_IF_ID -- requirements
Module: pipe_IF_ID

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port instruction, input, 16, fetched instruction word.
REQ-004 SHALL have port pc_cur, input, 16, address of fetched instruction.
REQ-005 SHALL have port pc_next, input, 16, pc_cur+2 from fetch adder.
REQ-006 SHALL have port fetch_valid, input, 1, instruction/pc inputs meaningful this cycle.
REQ-007 SHALL have port stall_decode, input, 1, hazard unit hold request (same signal feeding ID/EX).
REQ-008 SHALL have port flush, input, 1, taken branch/jump redirect from later stage.
REQ-009 SHALL have ports instruction_o, pc_cur_o, pc_next_o, outputs, 16 each, registered copies.
REQ-010 SHALL have port valid_o, output, 1, registered contents are a real instruction.
REQ-011 SHALL have port stall_fetch_o, output, 1, PC write inhibit to fetch.
REQ-012 SHALL have port bubble_cnt_o, output, 16, inserted-bubble count (see Configuration).

Function
REQ-013 SHALL implement FSM states RST_BUB, RUN, HOLD, SQUASH, HALTED.
REQ-014 RST_BUB: load NOP (16'h0800), valid_o=0; next state RUN unconditionally unless flush (-> SQUASH).
REQ-015 Priority every cycle: rst > flush > stall_decode > normal load.
REQ-016 flush in any state: load NOP, valid_o=0, pc outputs 16'h0000, next SQUASH; stall_decode ignored that cycle.
REQ-017 SQUASH: discard incoming word (load NOP, valid_o=0) for exactly one cycle, then RUN; second flush here re-enters SQUASH.
REQ-018 RUN with stall_decode=1: hold all registered outputs unchanged, next HOLD.
REQ-019 HOLD: hold while stall_decode=1; on release load inputs in same edge, next RUN (or HALTED per REQ-021).
REQ-020 RUN/HOLD load with fetch_valid=0: load NOP, valid_o=0, pc outputs held.
REQ-021 Loading a valid word with instruction[15:11]==5'b00000 (HALT): register it with valid_o=1, next HALTED.
REQ-022 HALTED: load NOP, valid_o=0 every cycle; leave only on flush (-> SQUASH) or rst.
REQ-023 stall_fetch_o combinational = (stall_decode & ~flush) | (state==HALTED & ~flush) | (state==RST_BUB).
REQ-024 Latency: input to output exactly one clock when not held.

Reset
REQ-025 rst=1 at any edge, including mid-HOLD or HALTED: state RST_BUB, instruction_o=16'h0800, pc_cur_o=pc_next_o=16'h0000, valid_o=0, bubble_cnt_o=16'h0000.

Configuration
REQ-026 Macro PIPE_IF_ID_BUBBLE_CNT_EN defined: bubble_cnt_o increments by 1 on each edge loading valid_o=0 outside RST_BUB and HALTED, saturating at 16'hFFFF; held cycles do not count.
REQ-027 Macro undefined: no counter flops; bubble_cnt_o constant 16'h0000.

Structure
REQ-028 Shared package SHALL hold NOP encoding 16'h0800, HALT opcode 5'b00000, FSM state encoding (3-bit).
REQ-029 Registers SHALL be built from existing dff cells plus one sub-module dff_en (enable-hold mux around dff), instantiated per field.

Verification
REQ-030 rst 1 cycle, fetch_valid=1, instr 16'hC123 -> cycle1 valid_o=0 instr 16'h0800, stall_fetch_o=1; cycle2 instr_o 16'hC123 valid_o=1.
REQ-031 RUN, stall_decode=1 for 3 cycles, inputs changing -> outputs frozen 3 cycles, stall_fetch_o=1; release loads current input next edge.
REQ-032 stall_decode=1 and flush=1 same cycle -> valid_o=0, stall_fetch_o=0; next fetched word also dropped; word after that appears valid.
REQ-033 Load 16'h0000 valid -> valid_o=1 then NOP/valid 0 forever, stall_fetch_o=1; flush releases via SQUASH to RUN.
REQ-034 With PIPE_IF_ID_BUBBLE_CNT_EN: 5 fetch_valid=0 cycles + 1 flush -> bubble_cnt_o=7 (flush+SQUASH+5); preload 16'hFFFF stays 16'hFFFF; without macro reads 0.
